// File: rtl/adder_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// adder_arb_pkg: shared types and round-robin pick for adder_arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package adder_arb_pkg;

  localparam int N_REQ_MAX = 8;
  localparam int ID_W      = $clog2(N_REQ_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // First set bit at or above ptr, wrapping modulo n; only the low n bits count.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ_MAX-1:0] req,
                                              input logic [ID_W-1:0]      ptr,
                                              input int                   n);
    logic [ID_W-1:0] win;
    logic            found;
    int              idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ_MAX; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!found && (i < n) && req[idx[ID_W-1:0]]) begin
        win   = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_arbiter_if.sv
// ----------------------------------------------------------------------------
// adder_arbiter_if / adder_port_if: client bus and adder bus bundles. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface adder_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       done;
  logic [WIDTH-1:0]       res_out;
  logic                   ovf_out;
  logic                   err_out;

  // master = requester side, slave = arbiter side
  modport master (output req, req_a, req_b,
                  input  done, res_out, ovf_out, err_out);
  modport slave  (input  req, req_a, req_b,
                  output done, res_out, ovf_out, err_out);
endinterface

interface adder_port_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_start;
  logic [WIDTH-1:0] add_res;
  logic             add_ovf;
  logic             add_ready;

  // master = arbiter side, slave = adder side
  modport master (output add_a, add_b, add_start,
                  input  add_res, add_ovf, add_ready);
  modport slave  (input  add_a, add_b, add_start,
                  output add_res, add_ovf, add_ready);
endinterface

`default_nettype wire

// File: rtl/adder_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter: combinational rotate-priority encoder. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id
);

  logic [N_REQ_MAX-1:0] req_ext;

  always_comb begin
    req_ext            = '0;
    req_ext[N_REQ-1:0] = req;
  end

  assign gnt_valid = |req;
  assign gnt_id    = rr_pick(req_ext, ptr, N_REQ);

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ----------------------------------------------------------------------------
// adder_arbiter: round-robin sharing of one multi-cycle adder. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  adder_arbiter_if.slave  cli,
  adder_port_if.master    add,
  output logic            busy
);

  localparam int         CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RESP  = RESP;

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  ptr_next;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_q;
  logic             ovf_q;
  logic             err_q;
  logic [CNT_W-1:0] wd_cnt;
  logic [N_REQ-1:0] done_w;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req       (cli.req),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign ptr_next = (int'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      wd_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            id_q  <= gnt_id;
            op_a  <= cli.req_a[int'(gnt_id)*WIDTH +: WIDTH];
            op_b  <= cli.req_b[int'(gnt_id)*WIDTH +: WIDTH];
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A ready in the final watchdog cycle still wins over the timeout.
          if (add.add_ready) begin
            res_q <= add.add_res;
            ovf_q <= add.add_ovf;
            err_q <= 1'b0;
            state <= ST_RESP;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b1;
            state <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          rr_ptr <= ptr_next;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    done_w = '0;
    if (state == ST_RESP) done_w = N_REQ'(1) << id_q;
  end

  assign busy          = (state != ST_IDLE);
  assign add.add_a     = op_a;
  assign add.add_b     = op_b;
  assign add.add_start = (state == ST_ISSUE);

  assign cli.done      = done_w;
  assign cli.res_out   = (state == ST_RESP) ? res_q : '0;
  assign cli.ovf_out   = (state == ST_RESP) && ovf_q;
  assign cli.err_out   = (state == ST_RESP) && err_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ----------------------------------------------------------------------------
// tb_adder_arbiter: directed self-checking bench with a 5-cycle adder model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_adder_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic stub = 1'b0;
  logic busy;
  int   tests = 0;
  int   fails = 0;

  adder_arbiter_if #(.N_REQ(N), .WIDTH(W)) cli ();
  adder_port_if    #(.WIDTH(W))            add ();

  adder_arbiter #(
    .N_REQ   (N),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cli  (cli),
    .add  (add),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Adder model: ready pulses 5 cycles after the start cycle; stub suppresses it.
  logic         pend;
  int unsigned  acnt;
  logic [W-1:0] pa, pb;
  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0; acnt <= 0; pa <= '0; pb <= '0;
      add.add_ready <= 1'b0; add.add_res <= '0; add.add_ovf <= 1'b0;
    end else if (add.add_start) begin
      pend <= 1'b1; acnt <= 3; pa <= add.add_a; pb <= add.add_b;
      add.add_ready <= 1'b0;
    end else if (pend) begin
      if (acnt == 0) begin
        pend <= 1'b0;
        add.add_ready <= !stub;
        {add.add_ovf, add.add_res} <= {1'b0, pa} + {1'b0, pb};
      end else begin
        acnt <= acnt - 1;
      end
    end else begin
      add.add_ready <= 1'b0;
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    cli.req_a[i*W +: W] = a;
    cli.req_b[i*W +: W] = b;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (cli.done == '0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (cli.done == '0) begin
      tests++; fails++;
      $display("FAIL wait_done: no done pulse within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    tests++; if (cli.done !== 4'b0) begin fails++; $display("FAIL reset_done: got %0h expected 0", cli.done); end
    tests++; if (add.add_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %0h expected 0", add.add_start); end
    tests++; if (cli.res_out !== 32'h0) begin fails++; $display("FAIL reset_res: got %0h expected 0", cli.res_out); end
    tests++; if (cli.err_out !== 1'b0) begin fails++; $display("FAIL reset_err: got %0h expected 0", cli.err_out); end
    tests++; if (add.add_a !== 32'h0 || add.add_b !== 32'h0) begin fails++; $display("FAIL reset_operands: got %0h/%0h expected 0/0", add.add_a, add.add_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int c;
    set_op(0, 32'h0000_00FF, 32'h0000_0001);
    cli.req = 4'b0001;
    @(negedge clk);
    tests++; if (add.add_start !== 1'b1) begin fails++; $display("FAIL single_start: got %0h expected 1", add.add_start); end
    tests++; if (add.add_a !== 32'hFF || add.add_b !== 32'h1) begin fails++; $display("FAIL single_operands: got %0h/%0h expected ff/1", add.add_a, add.add_b); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %0h expected 1", busy); end
    @(negedge clk);
    tests++; if (add.add_start !== 1'b0) begin fails++; $display("FAIL single_start_pulse: got %0h expected 0", add.add_start); end
    wait_done(40, c);
    tests++; if (c + 2 !== 7) begin fails++; $display("FAIL single_latency: got %0d expected 7", c + 2); end
    tests++; if (cli.done !== 4'b0001) begin fails++; $display("FAIL single_done: got %0h expected 1", cli.done); end
    tests++; if (cli.res_out !== 32'h100 || cli.ovf_out !== 1'b0 || cli.err_out !== 1'b0) begin fails++; $display("FAIL single_result: got %0h/%0h/%0h expected 100/0/0", cli.res_out, cli.ovf_out, cli.err_out); end
    cli.req = 4'b0000;
    @(negedge clk);
    tests++; if (cli.done !== 4'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_after: got done %0h busy %0h expected 0/0", cli.done, busy); end
  endtask

  task automatic test_overflow();
    int c;
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0001);
    cli.req = 4'b0100;
    wait_done(40, c);
    tests++; if (cli.done !== 4'b0100) begin fails++; $display("FAIL ovf_done: got %0h expected 4", cli.done); end
    tests++; if (cli.res_out !== 32'h0 || cli.ovf_out !== 1'b1) begin fails++; $display("FAIL ovf_result: got %0h/%0h expected 0/1", cli.res_out, cli.ovf_out); end
    cli.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int c;
    logic [W-1:0] a_v[4] = '{32'h11, 32'h222, 32'h3333, 32'h44444};
    logic [W-1:0] b_v[4] = '{32'h1, 32'h10, 32'h100, 32'h1000};
    logic [W-1:0] s_v[4] = '{32'h12, 32'h232, 32'h3433, 32'h45444};
    logic [3:0]   exp_d;
    int           order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, a_v[i], b_v[i]);
    cli.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(40, c);
      exp_d = 4'b0001 << order[k];
      tests++; if (c !== 7) begin fails++; $display("FAIL rr_spacing_%0d: got %0d expected 7", k, c); end
      tests++; if (cli.done !== exp_d || cli.res_out !== s_v[order[k]]) begin fails++; $display("FAIL rr_grant_%0d: got %0h/%0h expected %0h/%0h", k, cli.done, cli.res_out, exp_d, s_v[order[k]]); end
      if (k == 4) cli.req = 4'b0000;
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    int c;
    int seen = 0;
    set_op(1, 32'h5, 32'h6);
    cli.req = 4'b0010;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cli.req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (busy !== 1'b0 || cli.done !== 4'b0) begin fails++; $display("FAIL midrst_idle: got busy %0h done %0h expected 0/0", busy, cli.done); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cli.done !== 4'b0) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen); end
    set_op(0, 32'h7, 32'h8);
    cli.req = 4'b0001;
    wait_done(40, c);
    tests++; if (c !== 7 || cli.done !== 4'b0001 || cli.res_out !== 32'hF) begin fails++; $display("FAIL midrst_new: got %0d/%0h/%0h expected 7/1/f", c, cli.done, cli.res_out); end
    cli.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    int c;
    stub = 1'b1;
    set_op(2, 32'h1, 32'h2);
    cli.req = 4'b0100;
    wait_done(60, c);
    tests++; if (c !== 2 + TO) begin fails++; $display("FAIL wd_latency: got %0d expected %0d", c, 2 + TO); end
    tests++; if (cli.done !== 4'b0100 || cli.err_out !== 1'b1) begin fails++; $display("FAIL wd_err: got %0h/%0h expected 4/1", cli.done, cli.err_out); end
    tests++; if (cli.res_out !== 32'h0 || cli.ovf_out !== 1'b0) begin fails++; $display("FAIL wd_res: got %0h/%0h expected 0/0", cli.res_out, cli.ovf_out); end
    cli.req = 4'b0000;
    stub = 1'b0;
    @(negedge clk);
    set_op(0, 32'h10, 32'h20);
    set_op(3, 32'h30, 32'h40);
    cli.req = 4'b1001;
    wait_done(40, c);
    tests++; if (cli.done !== 4'b1000 || cli.res_out !== 32'h70 || cli.err_out !== 1'b0) begin fails++; $display("FAIL wd_ptr_adv: got %0h/%0h/%0h expected 8/70/0", cli.done, cli.res_out, cli.err_out); end
    cli.req = 4'b0001;
    @(negedge clk);
    wait_done(40, c);
    tests++; if (c !== 7 || cli.done !== 4'b0001 || cli.res_out !== 32'h30) begin fails++; $display("FAIL wd_wrap: got %0d/%0h/%0h expected 7/1/30", c, cli.done, cli.res_out); end
    cli.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c;
    set_op(0, 32'h100, 32'h200);
    cli.req = 4'b0001;
    repeat (3) @(negedge clk);
    set_op(3, 32'hAAAA_0000, 32'h5555_FFFF);
    cli.req = 4'b1001;
    wait_done(40, c);
    tests++; if (c !== 4 || cli.done !== 4'b0001 || cli.res_out !== 32'h300) begin fails++; $display("FAIL late_first: got %0d/%0h/%0h expected 4/1/300", c, cli.done, cli.res_out); end
    cli.req = 4'b1000;
    @(negedge clk);
    wait_done(40, c);
    tests++; if (c !== 7 || cli.done !== 4'b1000) begin fails++; $display("FAIL late_grant: got %0d/%0h expected 7/8", c, cli.done); end
    tests++; if (cli.res_out !== 32'hFFFF_FFFF || cli.ovf_out !== 1'b0) begin fails++; $display("FAIL late_result: got %0h/%0h expected ffffffff/0", cli.res_out, cli.ovf_out); end
    cli.req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    cli.req   = '0;
    cli.req_a = '0;
    cli.req_b = '0;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_mid_reset();
    test_watchdog();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one sequential_adder-class 32-bit multi-cycle adder between N_REQ requesters.
- Arbitrates round-robin, captures the winner's operands, pulses the adder's start, waits for ready, and returns res/overflow to the winner with a one-cycle done pulse.
- Includes a watchdog that reports an error if the adder never responds.
- Sits between client blocks and a single adder instance; the adder shares clk/rst with this block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width; must match the adder.
- TIMEOUT, 16, maximum cycles in WAIT before the watchdog fires.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-requester request level.
- req_a  in  N_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand b, same packing.
- done  out  N_REQ  one-hot, one-cycle completion pulse.
- res_out  out  WIDTH  result, valid only while done != 0.
- ovf_out  out  1  carry-out, valid with done.
- err_out  out  1  watchdog error, valid with done.
- busy  out  1  high whenever state != IDLE.
- add_a  out  WIDTH  operand a to the adder.
- add_b  out  WIDTH  operand b to the adder.
- add_start  out  1  start pulse to the adder.
- add_res  in  WIDTH  adder result.
- add_ovf  in  1  adder overflow.
- add_ready  in  1  adder ready pulse.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - state=IDLE, rr_ptr=0, watchdog count=0.
  - done=0, res_out=0, ovf_out=0, err_out=0, busy=0, add_start=0.
  - add_a/add_b = 0 (operand registers cleared).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, pick the winner: the first set bit at or above rr_ptr, wrapping modulo N_REQ.
  - Latch winner id, req_a[id] and req_b[id] into the operand registers. Next state ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE:
  - add_start=1 for exactly this cycle; add_a/add_b driven from the operand registers, held stable until RESP.
  - Next state WAIT; watchdog count cleared.
- WAIT:
  - When add_ready=1: capture add_res/add_ovf, err=0, go to RESP.
  - Otherwise increment the count. When the count reaches TIMEOUT-1 without ready: err=1, res=0, ovf=0, go to RESP.
- RESP:
  - done[id]=1, res_out/ovf_out/err_out driven from the captured values.
  - rr_ptr = (id+1) mod N_REQ. Next state IDLE.
- Outputs outside RESP: done=0; res_out/ovf_out/err_out are forced to 0.
- Latency: req sampled in IDLE at cycle T → add_start at T+1 → adder ready at T+6 → done at T+7. Minimum spacing between consecutive grants is 8 cycles.
- Requester rule:
  - Hold req and operands stable until granted; operands are sampled only in the IDLE grant cycle.
  - After done, deassert req on the next cycle or it is treated as a new request.
  - A req that drops after grant does not cancel the operation; done still pulses.
- add_ready outside WAIT is ignored.
- A request arriving while busy waits; no request is lost as long as it stays asserted.
- rst asserted in any state returns to IDLE next edge with reset values; an in-flight operation is discarded with no done pulse. The shared rst also clears the adder.
- Fairness: with all requesters active, grants rotate 0,1,..,N_REQ-1,0 with no starvation.

Decomposition:
- Package adder_arb_pkg:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, RESP}.
  - N_REQ_MAX=8.
  - Function rr_pick(req, ptr), returning the winner index.
- One sub-module, rr_arbiter: combinational rotate-priority encoder with inputs req and ptr, outputs gnt_valid and gnt_id.
- FSM, operand/result registers and watchdog stay in adder_arbiter.

Test Plan:
- Single request: req=0001, a=0x000000FF, b=0x00000001 → add_start at T+1; done=0001 at T+7 with res_out=0x00000100, ovf=0, err=0.
- Overflow: requester 2, a=0xFFFFFFFF, b=0x00000001 → done=0100, res_out=0x00000000, ovf_out=1.
- Round-robin: req=1111 held, each requester re-requesting after its done → done order 0,1,2,3,0 at 8-cycle spacing, each with its own sum.
- Mid-op reset: rst pulsed at T+3 of an operation → no done; busy=0 next cycle; a new req completes normally.
- Watchdog: stub adder that never asserts ready → after TIMEOUT cycles in WAIT, done[id]=1, err_out=1, res_out=0; rr_ptr advances.
- Late request: requester 3 raises req while requester 0 is in WAIT → requester 3 is granted in the IDLE cycle after requester 0's RESP; both results are correct.
